dsp_fir_mc: RTL and testbench

Parametrised multi-channel FIR filter, successor to the single-channel fixed 4-tap FIR top in the DSP datapath.
- One time-multiplexed MAC serves CHANNELS independent delay lines that share one runtime-loadable coefficient bank.
- Streaming valid/ready on input and output; Q-format rounding and saturation on the result.
- Sits between the sample source and downstream DSP stages.

---
 rtl/dsp_pkg.sv | 50 +++++
 rtl/dsp_fir_mac.sv | 64 ++++++
 rtl/dsp_fir_mc.sv | 163 ++++++++++++++++
 tb/tb_dsp_fir_mc.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP types, default widths and helpers.
// Used by dsp_fir_mc and its MAC datapath dsp_fir_mac.
package dsp_pkg;

  localparam int DSP_DATA_W = 16;
  localparam int DSP_COEF_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Round half up, then clamp to a signed dw-bit range.
  function automatic sat_res_t sat_round(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 dw
  );
    sat_res_t          res;
    logic signed [63:0] r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    r = acc;
    if (frac > 0)
      r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (dw - 1));
    res.sat = 1'b0;
    res.val = r;
    if (r > mx) begin
      res.sat = 1'b1;
      res.val = mx;
    end else if (r < mn) begin
      res.sat = 1'b1;
      res.val = mn;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_fir_mac.sv
// dsp_fir_mac: registered multiply-accumulate with clear/enable
// and a round/saturate output register loaded on the last tap.
module dsp_fir_mac
  import dsp_pkg::*;
#(
  parameter int DATA_W    = DSP_DATA_W,
  parameter int COEF_W    = DSP_COEF_W,
  parameter int ACC_W     = 35,
  parameter int FRAC_BITS = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_c,
  input  logic                     i_ld,
  input  logic signed [DATA_W-1:0] i_ld_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] r_out;
  logic                     r_sat;
  sat_res_t                 w_res;
  logic                     w_unused;

  assign w_prod   = ACC_W'(i_x) * ACC_W'(i_c);
  assign w_sum    = r_acc + w_prod;
  assign w_res    = sat_round(64'(w_sum), FRAC_BITS, DATA_W);
  assign w_unused = ^w_res.val[63:DATA_W];

  // Accumulator: cleared on sample accept, adds one product per MAC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_acc <= '0;
    else if (i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= w_sum;
  end

  // Output stage: captures the final rounded sum, or a bypassed sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_sat <= 1'b0;
    end else if (i_ld) begin
      r_out <= i_ld_data;
      r_sat <= 1'b0;
    end else if (i_en && i_last) begin
      r_out <= w_res.val[DATA_W-1:0];
      r_sat <= w_res.sat;
    end
  end

  assign o_data = r_out;
  assign o_sat  = r_sat;

endmodule

// File: rtl/dsp_fir_mc.sv
// dsp_fir_mc: multi-channel FIR, one time-shared MAC, shared coefs.
// Optional DSP_FIR_BYPASS_EN adds a bypass input (IDLE->OUT directly).
module dsp_fir_mc
  import dsp_pkg::*;
#(
  parameter int DATA_W    = DSP_DATA_W,
  parameter int COEF_W    = DSP_COEF_W,
  parameter int TAPS      = 8,
  parameter int CHANNELS  = 2,
  parameter int FRAC_BITS = 15,
  localparam int CH_W     = clog2_min1(CHANNELS),
  localparam int TAP_W    = clog2_min1(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_chan,
`ifdef DSP_FIR_BYPASS_EN
  input  logic                     bypass,
`endif
  input  logic                     coef_we,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     sat_flag,
  output logic                     err_pulse
);

  localparam int ACC_W = DATA_W + COEF_W + TAP_W;

  fir_state_e               r_state;
  logic [TAP_W-1:0]         r_k;
  logic [CH_W-1:0]          r_chan;
  logic [CH_W-1:0]          r_out_chan;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_err;
  logic signed [DATA_W-1:0] r_dl [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];

  logic                     w_acc;
  logic                     w_bad;
  logic                     w_take;
  logic                     w_byp;
  logic                     w_last;
  logic                     w_en;
  logic signed [DATA_W-1:0] w_x;
  logic signed [COEF_W-1:0] w_c;

`ifdef DSP_FIR_BYPASS_EN
  assign w_byp = bypass;
`else
  assign w_byp = 1'b0;
`endif

  assign w_acc  = in_valid && r_in_ready;
  assign w_bad  = int'(in_chan) >= CHANNELS;
  assign w_take = w_acc && !w_bad;
  assign w_last = r_k == TAP_W'(TAPS - 1);
  assign w_en   = r_state == MAC;
  assign w_x    = r_dl[r_chan][r_k];
  assign w_c    = r_coef[r_k];

  // Coefficient bank: writes land only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++)
        r_coef[i] <= '0;
    end else if (coef_we && r_state == IDLE) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // Per-channel delay lines: newest sample enters at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < TAPS; i++)
          r_dl[c][i] <= '0;
    end else if (w_take) begin
      r_dl[in_chan][0] <= in_data;
      for (int i = 1; i < TAPS; i++)
        r_dl[in_chan][i] <= r_dl[in_chan][i-1];
    end
  end

  // Control FSM: accept, step through taps, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_chan      <= '0;
      r_out_chan  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (coef_we && r_state != IDLE) || (w_acc && w_bad);
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            r_chan     <= in_chan;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            if (w_byp) begin
              r_state     <= OUT;
              r_out_valid <= 1'b1;
              r_out_chan  <= in_chan;
            end else begin
              r_state <= MAC;
            end
          end
        end
        MAC: begin
          r_k <= r_k + 1'b1;
          if (w_last) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
            r_out_chan  <= r_chan;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dsp_fir_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_take),
    .i_en      (w_en),
    .i_last    (w_last),
    .i_x       (w_x),
    .i_c       (w_c),
    .i_ld      (w_take && w_byp),
    .i_ld_data (in_data),
    .o_data    (out_data),
    .o_sat     (sat_flag)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign err_pulse = r_err;

endmodule

// File: tb/tb_dsp_fir_mc.sv
// tb_dsp_fir_mc: table vectors, corner sequences and random traffic
// checked against a plain-arithmetic FIR model.
module tb_dsp_fir_mc;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 8;
  localparam int CH   = 3;
  localparam int FB   = 15;
  localparam int CHW  = 2;
  localparam int TW   = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [CHW-1:0]       in_chan;
  logic                 coef_we;
  logic [TW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [CHW-1:0]       out_chan;
  logic                 sat_flag;
  logic                 err_pulse;

  always #5 clk = ~clk;

  dsp_fir_mc #(
    .DATA_W(DW), .COEF_W(CW), .TAPS(TAPS),
    .CHANNELS(CH), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chan(in_chan),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan),
    .sat_flag(sat_flag), .err_pulse(err_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;

  longint m_dl [CH][TAPS];
  longint m_coef [TAPS];

  typedef struct {
    int ch;
    int x;
    int exp_d;
    int exp_s;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++)
        m_dl[c][k] = 0;
    for (int k = 0; k < TAPS; k++)
      m_coef[k] = 0;
  endfunction

  function automatic void m_push(input int ch, input longint x);
    for (int k = TAPS - 1; k > 0; k--)
      m_dl[ch][k] = m_dl[ch][k-1];
    m_dl[ch][0] = x;
  endfunction

  task automatic m_res(input int ch, output longint d,
                       output longint s);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      acc += m_dl[ch][k] * m_coef[k];
    r = (acc + 16384) >>> FB;
    s = 0;
    d = r;
    if (r > 32767) begin
      d = 32767;
      s = 1;
    end else if (r < -32768) begin
      d = -32768;
      s = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50)
      chk("in_ready_timeout", longint'(in_ready), 1);
  endtask

  task automatic wcoef(input int a, input int d);
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = TW'(a);
    coef_data = CW'(d);
    @(negedge clk);
    coef_we = 1'b0;
    m_coef[a] = longint'($signed(CW'(d)));
  endtask

  task automatic start(input int ch, input int x);
    wait_idle();
    in_valid = 1'b1;
    in_chan  = CHW'(ch);
    in_data  = DW'(x);
    @(negedge clk);
    in_valid = 1'b0;
    if (ch < CH)
      m_push(ch, longint'($signed(DW'(x))));
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid)
      chk("out_valid_timeout", 0, 1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input int ch, input int x, input string nm);
    int     lat;
    longint d;
    longint s;
    start(ch, x);
    wait_out(lat);
    m_res(ch, d, s);
    chk({nm, "_lat"}, lat, TAPS + 1);
    chk({nm, "_data"}, longint'(out_data), d);
    chk({nm, "_sat"}, longint'(sat_flag), s);
    chk({nm, "_chan"}, longint'(out_chan), ch);
    pop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int     lat;
    int     hold;
    longint d;
    longint s;

    tbl[0] = '{0, 1000, 500, 0};
    tbl[1] = '{0, 3, 2, 0};
    tbl[2] = '{0, -3, -1, 0};
    tbl[3] = '{1, -1000, -500, 0};
    tbl[4] = '{2, 32767, 16384, 0};
    tbl[5] = '{0, -32768, -16384, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chan   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    m_clear();
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_chan", longint'(out_chan), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_err", longint'(err_pulse), 0);
    do_reset();

    // impulse / rounding table with coef[0] = 0.5
    wcoef(0, 16'h4000);
    for (int i = 0; i < 6; i++) begin
      start(tbl[i].ch, tbl[i].x);
      wait_out(lat);
      chk($sformatf("tbl%0d_lat", i), lat, TAPS + 1);
      chk($sformatf("tbl%0d_data", i),
          longint'(out_data), tbl[i].exp_d);
      chk($sformatf("tbl%0d_sat", i),
          longint'(sat_flag), tbl[i].exp_s);
      chk($sformatf("tbl%0d_chan", i),
          longint'(out_chan), tbl[i].ch);
      pop();
    end

    // saturation
    for (int k = 0; k < TAPS; k++)
      wcoef(k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++)
      run(0, 32'h7FFF, "satp");
    chk("satp_final", longint'(out_data), 32767);
    chk("satp_flag", longint'(sat_flag), 1);
    for (int i = 0; i < TAPS; i++)
      run(0, -32768, "satn");
    chk("satn_final", longint'(out_data), -32768);
    chk("satn_flag", longint'(sat_flag), 1);

    // channel isolation
    do_reset();
    wcoef(1, 16'h7FFF);
    run(0, 100, "iso_a");
    run(1, 50, "iso_b");
    run(0, 0, "iso_c");
    chk("iso_const", longint'(out_data), 100);

    // bad channel
    start(3, 55);
    chk("bad_err", longint'(err_pulse), 1);
    chk("bad_ready", longint'(in_ready), 1);
    for (int i = 0; i < TAPS + 3; i++) begin
      chk("bad_no_out", longint'(out_valid), 0);
      @(negedge clk);
    end
    chk("bad_err_once", longint'(err_pulse), 0);

    // coefficient write during MAC, then backpressure
    start(1, 20);
    coef_we   = 1'b1;
    coef_addr = TW'(1);
    coef_data = '0;
    @(negedge clk);
    coef_we = 1'b0;
    chk("mac_we_err", longint'(err_pulse), 1);
    wait_out(lat);
    m_res(1, d, s);
    chk("bp_data", longint'(out_data), d);
    chk("bp_const", longint'(out_data), 50);
    hold = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", longint'(out_data), hold);
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    pop();
    run(1, 30, "coef_kept");
    chk("coef_kept_const", longint'(out_data), 20);

    // reset during accumulation
    wcoef(0, 16'h4000);
    start(0, 1000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_ready", longint'(in_ready), 1);
    chk("mid_rst_data", longint'(out_data), 0);
    chk("mid_rst_chan", longint'(out_chan), 0);
    chk("mid_rst_sat", longint'(sat_flag), 0);
    chk("mid_rst_err", longint'(err_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    run(0, 1000, "post_rst");
    chk("post_rst_zero", longint'(out_data), 0);

    // random traffic against the model
    for (int k = 0; k < TAPS; k++)
      wcoef(k, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        wcoef(int'($urandom_range(0, TAPS - 1)),
              int'($urandom_range(0, 65535)));
      run(int'($urandom_range(0, CH - 1)),
          int'($urandom_range(0, 65535)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
